// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file writeback path.
package rf_pkg;

  localparam int NUM_REGS  = 32;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Writeback result FIFO: two ordered push ports per cycle, one pop port.
module wb_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push0,
  input  wb_entry_t                    entry0,
  input  logic                         push1,
  input  wb_entry_t                    entry1,
  input  logic                         pop,
  output wb_entry_t                    head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr1;
  logic [CNT_W-1:0] count_q;
  logic             pop_ok;

  // push1 lands right behind push0 when both are present, otherwise at wr_ptr
  assign wr_ptr1 = push0 ? wr_ptr + PTR_W'(1) : wr_ptr;
  assign pop_ok  = pop && (count_q != '0);

  always_ff @(posedge clock) begin
    if (reset_n) begin
      if (push0) mem[wr_ptr]  <= entry0;
      if (push1) mem[wr_ptr1] <= entry1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PTR_W'(push0) + PTR_W'(push1);
      if (pop_ok) rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop_ok);
    end
  end

  assign head  = mem[rd_ptr];
  assign count = count_q;

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Writeback controller: arbitrates ALU/load results into the FIFO, drains one
// write per cycle to the register file and tracks per-register pending writes.
module rf_writeback_ctrl #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         issue_valid,
  input  logic [4:0]                   issue_rd,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [4:0]                   alu_rd,
  input  logic [XLEN-1:0]              alu_data,
  input  logic                         ld_valid,
  output logic                         ld_ready,
  input  logic [4:0]                   ld_rd,
  input  logic [XLEN-1:0]              ld_data,
  output logic                         rf_enable_write,
  output logic [4:0]                   rf_index_write,
  output logic [XLEN-1:0]              rf_write_data,
  input  logic [4:0]                   query_a,
  input  logic [4:0]                   query_b,
  output logic                         busy_a,
  output logic                         busy_b,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

  import rf_pkg::*;

  localparam int CNT_W = $clog2(DEPTH+1);

  wb_entry_t             alu_entry;
  wb_entry_t             ld_entry;
  wb_entry_t             head;
  logic                  alu_push;
  logic                  ld_push;
  logic                  drain;
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_next;

  // Readies deliberately ignore the same-cycle pop.
  assign alu_ready = reset_n && (fifo_count < CNT_W'(DEPTH));
  assign ld_ready  = reset_n &&
                     ((fifo_count + CNT_W'(alu_valid && alu_ready)) < CNT_W'(DEPTH));

  // Writes to x0 complete the handshake but never enter the queue.
  assign alu_push = alu_valid && alu_ready && (alu_rd != '0);
  assign ld_push  = ld_valid && ld_ready && (ld_rd != '0);

  assign alu_entry.rd   = alu_rd;
  assign alu_entry.data = alu_data;
  assign ld_entry.rd    = ld_rd;
  assign ld_entry.data  = ld_data;

  assign drain = (fifo_count != '0);

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push0   (alu_push),
    .entry0  (alu_entry),
    .push1   (ld_push),
    .entry1  (ld_entry),
    .pop     (drain),
    .head    (head),
    .count   (fifo_count)
  );

  assign rf_enable_write = reset_n && drain;
  assign rf_index_write  = rf_enable_write ? head.rd : '0;
  assign rf_write_data   = rf_enable_write ? head.data : '0;

  // A new issue to the register being committed keeps it busy.
  always_comb begin
    pending_next = pending;
    if (drain) pending_next[head.rd] = 1'b0;
    if (issue_valid && (issue_rd != '0)) pending_next[issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) pending <= '0;
    else          pending <= pending_next;
  end

  assign busy_a = pending[query_a];
  assign busy_b = pending[query_b];

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Self-checking bench for rf_writeback_ctrl: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_rf_writeback_ctrl;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        rf_enable_write;
  logic [4:0]  rf_index_write;
  logic [31:0] rf_write_data;
  logic [4:0]  query_a = '0;
  logic [4:0]  query_b = '0;
  logic        busy_a;
  logic        busy_b;
  logic [2:0]  fifo_count;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  rf_writeback_ctrl #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .issue_valid     (issue_valid),
    .issue_rd        (issue_rd),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .ld_valid        (ld_valid),
    .ld_ready        (ld_ready),
    .ld_rd           (ld_rd),
    .ld_data         (ld_data),
    .rf_enable_write (rf_enable_write),
    .rf_index_write  (rf_index_write),
    .rf_write_data   (rf_write_data),
    .query_a         (query_a),
    .query_b         (query_b),
    .busy_a          (busy_a),
    .busy_b          (busy_b),
    .fifo_count      (fifo_count)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t mq[$];
  bit   mpend[32];

  function automatic bit m_alu_ready();
    return reset_n && (mq.size() < DEPTH);
  endfunction

  function automatic bit m_ld_ready();
    int alu_take;
    alu_take = (alu_valid && m_alu_ready()) ? 1 : 0;
    return reset_n && ((mq.size() + alu_take) < DEPTH);
  endfunction

  task automatic model_edge();
    bit   a;
    bit   l;
    ent_t e;
    a = alu_valid && m_alu_ready();
    l = ld_valid && m_ld_ready();
    if (!reset_n) begin
      mq.delete();
      foreach (mpend[i]) mpend[i] = 1'b0;
      return;
    end
    if (mq.size() > 0) begin
      mpend[mq[0].rd] = 1'b0;
      void'(mq.pop_front());
    end
    if (a && alu_rd != 0) begin e.rd = alu_rd; e.data = alu_data; mq.push_back(e); end
    if (l && ld_rd != 0)  begin e.rd = ld_rd;  e.data = ld_data;  mq.push_back(e); end
    if (issue_valid && issue_rd != 0) mpend[issue_rd] = 1'b1;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    issue_valid = 1'b0; alu_valid = 1'b0; ld_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44; query_a = 5'd4; query_b = 5'd4;
    tick();
    tick();
    total_cnt++; if (rf_enable_write !== 1'b0) $display("FAIL reset_en: got %0b expected 0", rf_enable_write); else pass_cnt++;
    total_cnt++; if (fifo_count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", fifo_count); else pass_cnt++;
    total_cnt++; if (alu_ready !== 1'b0) $display("FAIL reset_alu_ready: got %0b expected 0", alu_ready); else pass_cnt++;
    total_cnt++; if (ld_ready !== 1'b0) $display("FAIL reset_ld_ready: got %0b expected 0", ld_ready); else pass_cnt++;
    total_cnt++; if ({busy_a, busy_b} !== 2'b00) $display("FAIL reset_busy: got %0b expected 00", {busy_a, busy_b}); else pass_cnt++;
    reset_n = 1'b1; clear_inputs();
    #1;
    total_cnt++; if (alu_ready !== 1'b1) $display("FAIL release_alu_ready: got %0b expected 1", alu_ready); else pass_cnt++;
    tick();
  endtask

  task automatic test_single_write();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h12345678;
    #1;
    total_cnt++; if (alu_ready !== 1'b1) $display("FAIL single_ready: got %0b expected 1", alu_ready); else pass_cnt++;
    tick();
    clear_inputs();
    #1;
    total_cnt++; if (rf_enable_write !== 1'b1) $display("FAIL single_en: got %0b expected 1", rf_enable_write); else pass_cnt++;
    total_cnt++; if (rf_index_write !== 5'd5) $display("FAIL single_idx: got %0d expected 5", rf_index_write); else pass_cnt++;
    total_cnt++; if (rf_write_data !== 32'h12345678) $display("FAIL single_data: got %0h expected 12345678", rf_write_data); else pass_cnt++;
    tick();
    total_cnt++; if (rf_enable_write !== 1'b0) $display("FAIL single_after_en: got %0b expected 0", rf_enable_write); else pass_cnt++;
  endtask

  task automatic test_dual_push();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hA;
    ld_valid = 1'b1;  ld_rd = 5'd7;  ld_data = 32'hB;
    tick();
    clear_inputs();
    #1;
    total_cnt++; if (fifo_count !== 3'd2) $display("FAIL dual_count2: got %0d expected 2", fifo_count); else pass_cnt++;
    total_cnt++; if (rf_index_write !== 5'd3 || rf_write_data !== 32'hA) $display("FAIL dual_first: got idx %0d data %0h expected idx 3 data a", rf_index_write, rf_write_data); else pass_cnt++;
    tick();
    total_cnt++; if (fifo_count !== 3'd1) $display("FAIL dual_count1: got %0d expected 1", fifo_count); else pass_cnt++;
    total_cnt++; if (rf_index_write !== 5'd7 || rf_write_data !== 32'hB) $display("FAIL dual_second: got idx %0d data %0h expected idx 7 data b", rf_index_write, rf_write_data); else pass_cnt++;
    tick();
    total_cnt++; if (fifo_count !== 3'd0 || rf_enable_write !== 1'b0) $display("FAIL dual_empty: got count %0d en %0b expected 0 0", fifo_count, rf_enable_write); else pass_cnt++;
  endtask

  task automatic test_full();
    logic [4:0]  exp_idx [5];
    logic [31:0] exp_dat [5];
    logic [4:0]  got_idx [$];
    logic [31:0] got_dat [$];
    exp_idx = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5};
    exp_dat = '{32'h101, 32'h201, 32'h103, 32'h204, 32'h105};
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h101;
    ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = 32'h201;
    #1;
    total_cnt++; if ({alu_ready, ld_ready} !== 2'b11) $display("FAIL full_ready0: got %0b expected 11", {alu_ready, ld_ready}); else pass_cnt++;
    tick();
    if (rf_enable_write) begin got_idx.push_back(rf_index_write); got_dat.push_back(rf_write_data); end
    alu_rd = 5'd3; alu_data = 32'h103; ld_rd = 5'd4; ld_data = 32'h204;
    #1;
    total_cnt++; if (fifo_count !== 3'd2 || ld_ready !== 1'b1) $display("FAIL full_step2: got count %0d ld_ready %0b expected 2 1", fifo_count, ld_ready); else pass_cnt++;
    tick();
    if (rf_enable_write) begin got_idx.push_back(rf_index_write); got_dat.push_back(rf_write_data); end
    alu_rd = 5'd5; alu_data = 32'h105; ld_rd = 5'd6; ld_data = 32'h206;
    #1;
    total_cnt++; if (fifo_count !== 3'd3) $display("FAIL full_count3: got %0d expected 3", fifo_count); else pass_cnt++;
    total_cnt++; if ({alu_ready, ld_ready} !== 2'b10) $display("FAIL full_backpressure: got %0b expected 10", {alu_ready, ld_ready}); else pass_cnt++;
    tick();
    clear_inputs();
    for (int i = 0; i < 6; i++) begin
      if (rf_enable_write) begin got_idx.push_back(rf_index_write); got_dat.push_back(rf_write_data); end
      tick();
    end
    total_cnt++; if (got_idx.size() != 5) $display("FAIL full_write_count: got %0d expected 5", got_idx.size()); else pass_cnt++;
    for (int i = 0; i < 5 && i < got_idx.size(); i++) begin
      total_cnt++;
      if (got_idx[i] !== exp_idx[i] || got_dat[i] !== exp_dat[i])
        $display("FAIL full_order[%0d]: got idx %0d data %0h expected idx %0d data %0h", i, got_idx[i], got_dat[i], exp_idx[i], exp_dat[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_scoreboard();
    query_a = 5'd12; query_b = 5'd0;
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    clear_inputs();
    #1;
    total_cnt++; if (busy_a !== 1'b1) $display("FAIL sb_issue_busy: got %0b expected 1", busy_a); else pass_cnt++;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'd103;
    tick();
    clear_inputs();
    #1;
    total_cnt++; if (busy_a !== 1'b1 || rf_index_write !== 5'd12 || rf_write_data !== 32'd103) $display("FAIL sb_during_write: got busy %0b idx %0d data %0d expected 1 12 103", busy_a, rf_index_write, rf_write_data); else pass_cnt++;
    tick();
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL sb_cleared: got %0b expected 0", busy_a); else pass_cnt++;
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    issue_valid = 1'b0; alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'd55;
    tick();
    alu_valid = 1'b0; issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    clear_inputs();
    #1;
    total_cnt++; if (busy_a !== 1'b1) $display("FAIL sb_set_wins: got %0b expected 1", busy_a); else pass_cnt++;
    alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'd56;
    tick();
    clear_inputs();
    tick();
    total_cnt++; if (busy_a !== 1'b0) $display("FAIL sb_final_clear: got %0b expected 0", busy_a); else pass_cnt++;
    issue_valid = 1'b1; issue_rd = 5'd0;
    tick();
    clear_inputs();
    #1;
    total_cnt++; if (busy_b !== 1'b0) $display("FAIL sb_x0_busy: got %0b expected 0", busy_b); else pass_cnt++;
  endtask

  task automatic test_x0_and_reset();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'hDEAD;
    #1;
    total_cnt++; if (alu_ready !== 1'b1) $display("FAIL x0_ready: got %0b expected 1", alu_ready); else pass_cnt++;
    tick();
    clear_inputs();
    #1;
    total_cnt++; if (fifo_count !== 3'd0 || rf_enable_write !== 1'b0) $display("FAIL x0_discard: got count %0d en %0b expected 0 0", fifo_count, rf_enable_write); else pass_cnt++;
    alu_valid = 1'b1; alu_rd = 5'd8;  alu_data = 32'h8;
    ld_valid  = 1'b1; ld_rd  = 5'd9;  ld_data  = 32'h9;
    tick();
    alu_rd = 5'd10; alu_data = 32'hA0; ld_rd = 5'd11; ld_data = 32'hB0;
    tick();
    clear_inputs();
    #1;
    total_cnt++; if (fifo_count !== 3'd3) $display("FAIL mid_queued: got %0d expected 3", fifo_count); else pass_cnt++;
    reset_n = 1'b0;
    #1;
    total_cnt++; if (rf_enable_write !== 1'b0 || rf_index_write !== 5'd0 || alu_ready !== 1'b0) $display("FAIL mid_reset_low: got en %0b idx %0d ready %0b expected 0 0 0", rf_enable_write, rf_index_write, alu_ready); else pass_cnt++;
    tick();
    reset_n = 1'b1;
    #1;
    total_cnt++; if (fifo_count !== 3'd0 || rf_enable_write !== 1'b0) $display("FAIL mid_after_reset: got count %0d en %0b expected 0 0", fifo_count, rf_enable_write); else pass_cnt++;
    tick();
    total_cnt++; if (rf_enable_write !== 1'b0) $display("FAIL mid_no_write: got %0b expected 0", rf_enable_write); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [4:0]  e_idx;
    logic [31:0] e_dat;
    logic [4:0]  cand;
    bit          e_en;
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset_n   = ($urandom_range(0, 49) != 0);
      alu_valid = $urandom_range(0, 2) != 0;
      alu_rd    = 5'($urandom_range(0, 31));
      alu_data  = $urandom;
      ld_valid  = $urandom_range(0, 2) != 0;
      ld_rd     = 5'($urandom_range(0, 31));
      ld_data   = $urandom;
      query_a   = 5'($urandom_range(0, 31));
      query_b   = 5'($urandom_range(0, 31));
      cand      = 5'($urandom_range(0, 31));
      issue_rd  = cand;
      issue_valid = ($urandom_range(0, 1) != 0) && !mpend[cand];
      #1;
      e_en  = reset_n && (mq.size() > 0);
      e_idx = e_en ? mq[0].rd : 5'd0;
      e_dat = e_en ? mq[0].data : 32'd0;
      total_cnt++; if (rf_enable_write !== e_en) $display("FAIL rnd_en@%0d: got %0b expected %0b", cyc, rf_enable_write, e_en); else pass_cnt++;
      total_cnt++; if (rf_index_write !== e_idx || rf_write_data !== e_dat) $display("FAIL rnd_write@%0d: got %0d/%0h expected %0d/%0h", cyc, rf_index_write, rf_write_data, e_idx, e_dat); else pass_cnt++;
      total_cnt++; if (fifo_count !== 3'(mq.size())) $display("FAIL rnd_count@%0d: got %0d expected %0d", cyc, fifo_count, mq.size()); else pass_cnt++;
      total_cnt++; if (alu_ready !== m_alu_ready() || ld_ready !== m_ld_ready()) $display("FAIL rnd_ready@%0d: got %0b%0b expected %0b%0b", cyc, alu_ready, ld_ready, m_alu_ready(), m_ld_ready()); else pass_cnt++;
      total_cnt++; if (busy_a !== mpend[query_a] || busy_b !== mpend[query_b]) $display("FAIL rnd_busy@%0d: got %0b%0b expected %0b%0b", cyc, busy_a, busy_b, mpend[query_a], mpend[query_b]); else pass_cnt++;
      tick();
    end
    reset_n = 1'b1;
    clear_inputs();
  endtask

  initial begin
    #1;
    test_reset();
    test_single_write();
    test_dual_push();
    test_full();
    test_scoreboard();
    test_x0_and_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
